// File: rtl/accum_cpu_controller.sv
// accum_cpu_controller: fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Owns PC, IR1 (opcode byte), IR2 (operand byte) and AC.
// Ports:
//   clk_i, rst_i (async, active-high), start_i (leave IDLE)
//   mem_addr_o/mem_wdata_o/mem_cs_o/mem_we_o/mem_oe_o -> sync RAM, mem_rdata_i <- RAM
//   alu_a_o (=AC), alu_b_c_o (=mem_rdata_i, combinational), alu_sel_o -> ALU, alu_result_i <- ALU
//   pc_o, ac_o, busy_o, halted_o, retire_o -> status
module accum_cpu_controller #(
    parameter logic [7:0] START_PC = 8'h00,
    parameter logic [3:0] ADD_SEL  = 4'h1,
    parameter logic [3:0] SUB_SEL  = 4'h2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic [7:0] mem_addr_o,
    output logic [7:0] mem_wdata_o,
    input  logic [7:0] mem_rdata_i,
    output logic       mem_cs_o,
    output logic       mem_we_o,
    output logic       mem_oe_o,
    output logic [7:0] alu_a_o,
    output logic [7:0] alu_b_c_o,
    output logic [3:0] alu_sel_o,
    input  logic [7:0] alu_result_i,
    output logic [7:0] pc_o,
    output logic [7:0] ac_o,
    output logic       busy_o,
    output logic       halted_o,
    output logic       retire_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH1, S_FETCH2, S_DECODE, S_OPER, S_WB, S_EXEC, S_HALT
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_SKIP  = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;
    localparam logic [3:0] OP_CLEAR = 4'hA;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       cs;
        logic       we;
        logic       oe;
        logic [3:0] sel;
        logic       busy;
        logic       halted;
        logic       retire;
    } out_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ac_q, ac_d;
    logic [7:0] ir1_q, ir1_d;
    logic [7:0] ir2_q, ir2_d;
    out_t       out_q, out_d;
    logic       skip_take;

    // Moore output decode; evaluated on next-state values so outputs come from flops.
    function automatic out_t decode_out(input state_t st, input logic [7:0] f_pc,
                                        input logic [7:0] f_ir1, input logic [7:0] f_ir2,
                                        input logic [7:0] f_ac);
        out_t       o;
        logic [3:0] op;
        o  = '0;
        op = f_ir1[7:4];
        case (st)
            S_FETCH1: begin
                o.addr = f_pc;
                o.cs   = 1'b1;
                o.oe   = 1'b1;
            end
            S_FETCH2: begin
                o.addr = 8'(f_pc + 8'd1);
                o.cs   = 1'b1;
                o.oe   = 1'b1;
            end
            S_DECODE: o.retire = (op == OP_HALT);
            S_OPER: begin
                o.addr = f_ir2;
                o.cs   = 1'b1;
                if (op == OP_STORE) begin
                    o.we     = 1'b1;
                    o.wdata  = f_ac;
                    o.retire = 1'b1;
                end else begin
                    o.oe = 1'b1;
                end
            end
            S_WB: begin
                if (op == OP_ADD)      o.sel = ADD_SEL;
                else if (op == OP_SUB) o.sel = SUB_SEL;
                o.retire = 1'b1;
            end
            S_EXEC: o.retire = 1'b1;
            S_HALT: o.halted = 1'b1;
            default: o = '0;
        endcase
        o.busy = (st != S_IDLE) && (st != S_HALT);
        return o;
    endfunction

    // SKIP condition on signed AC, selected by IR1[1:0].
    always_comb begin
        skip_take = 1'b0;
        case (ir1_q[1:0])
            2'b00:   skip_take = ac_q[7];
            2'b01:   skip_take = (ac_q == 8'h00);
            2'b10:   skip_take = !ac_q[7] && (ac_q != 8'h00);
            default: skip_take = 1'b0;
        endcase
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ac_d    = ac_q;
        ir1_d   = ir1_q;
        ir2_d   = ir2_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: begin
                ir1_d   = mem_rdata_i;
                pc_d    = 8'(pc_q + 8'd1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir2_d = mem_rdata_i;
                pc_d  = 8'(pc_q + 8'd1);
                case (ir1_q[7:4])
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB: state_d = S_OPER;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end
            S_OPER: state_d = (ir1_q[7:4] == OP_STORE) ? S_FETCH1 : S_WB;
            S_WB: begin
                if (ir1_q[7:4] == OP_LOAD) ac_d = mem_rdata_i;
                else                       ac_d = alu_result_i;
                state_d = S_FETCH1;
            end
            S_EXEC: begin
                case (ir1_q[7:4])
                    OP_SKIP:  if (skip_take) pc_d = 8'(pc_q + 8'd2);
                    OP_JUMP:  pc_d = ir2_q;
                    OP_CLEAR: ac_d = 8'h00;
                    default:  pc_d = pc_q;
                endcase
                state_d = S_FETCH1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        out_d = decode_out(state_d, pc_d, ir1_d, ir2_d, ac_d);
    end

    // State and output registers; async reset clears bus controls immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            ac_q    <= 8'h00;
            ir1_q   <= 8'h00;
            ir2_q   <= 8'h00;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            ir1_q   <= ir1_d;
            ir2_q   <= ir2_d;
            out_q   <= out_d;
        end
    end

    assign mem_addr_o  = out_q.addr;
    assign mem_wdata_o = out_q.wdata;
    assign mem_cs_o    = out_q.cs;
    assign mem_we_o    = out_q.we;
    assign mem_oe_o    = out_q.oe;
    assign alu_sel_o   = out_q.sel;
    assign busy_o      = out_q.busy;
    assign halted_o    = out_q.halted;
    assign retire_o    = out_q.retire;
    assign alu_a_o     = ac_q;
    assign alu_b_c_o   = mem_rdata_i;
    assign pc_o        = pc_q;
    assign ac_o        = ac_q;

endmodule

// File: tb/tb_accum_cpu_controller.sv
// Bench for accum_cpu_controller: RAM + ALU models, retire scoreboard, directed programs.
module tb_accum_cpu_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       load = 1'b0;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_res, pc, ac;
    logic       mem_cs, mem_we, mem_oe, busy, halted, retire;
    logic [3:0] alu_sel;

    logic [7:0] mem  [256];
    logic [7:0] prog [256];

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int         lat;
        logic [7:0] pc;
        logic [7:0] ac;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    accum_cpu_controller dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .mem_cs_o(mem_cs), .mem_we_o(mem_we), .mem_oe_o(mem_oe),
        .alu_a_o(alu_a), .alu_b_c_o(alu_b), .alu_sel_o(alu_sel), .alu_result_i(alu_res),
        .pc_o(pc), .ac_o(ac), .busy_o(busy), .halted_o(halted), .retire_o(retire)
    );

    // ALU model: 1 add, 2 sub.
    always_comb begin
        alu_res = 8'h00;
        if (alu_sel == 4'h1)      alu_res = 8'(alu_a + alu_b);
        else if (alu_sel == 4'h2) alu_res = 8'(alu_a - alu_b);
    end

    // Sync RAM model with a bulk program load.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
        end else if (mem_cs) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_oe) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_true(input string name, input logic cond);
        n_checks++;
        if (cond !== 1'b1) begin
            n_err++;
            $display("FAIL %s: condition false at t=%0t", name, $time);
        end
    endtask

    task automatic push(input int lat, input logic [7:0] p, input logic [7:0] a);
        exp_t e;
        e.lat = lat;
        e.pc  = p;
        e.ac  = a;
        exp_q.push_back(e);
    endtask

    // Monitor: latency per retire, then pc/ac one cycle later; we/oe exclusivity each cycle.
    initial begin
        exp_t cur;
        bit   pending;
        int   cnt;
        pending = 1'b0;
        cnt     = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt     = 0;
                pending = 1'b0;
            end else begin
                if (pending) begin
                    check("pc_after_retire", 32'(pc), 32'(cur.pc));
                    check("ac_after_retire", 32'(ac), 32'(cur.ac));
                    pending = 1'b0;
                end
                check_true("we_oe_exclusive", !(mem_we && mem_oe));
                if (busy) cnt++;
                if (retire) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_retire: actual=pc %0h required=no retire", pc);
                    end else begin
                        cur = exp_q.pop_front();
                        check("retire_latency", 32'(cnt), 32'(cur.lat));
                        pending = 1'b1;
                    end
                    cnt = 0;
                end
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_to_halt(input string name);
        int n;
        pulse_start();
        n = 0;
        while (!halted && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_true({name, "_halt_reached"}, halted);
        @(negedge clk);
        check(
            {name, "_scoreboard_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : stim
        logic [7:0] fib_code [28];
        logic [7:0] fib_data [6];
        logic [7:0] x, y, c, s;
        bit         found;

        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [7:0] fib_code [28];
        logic [7:0] fib_data [6];
        logic [7:0] x, y, c, s;
        bit         found;

        // Reset state
        clear_prog();
        do_reset();
        check("rst_cs", 32'(mem_cs), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_oe", 32'(mem_oe), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ac", 32'(ac), 32'd0);

        // 1: reset during STORE's write cycle
        clear_prog();
        prog[8'h00] = 8'h10; prog[8'h01] = 8'h05;
        prog[8'h02] = 8'h20; prog[8'h03] = 8'h06;
        prog[8'h05] = 8'hAA;
        do_reset();
        push(5, 8'h02, 8'hAA);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1;
            if (mem_we) found = 1'b1;
        end
        check_true("t1_store_reached", found);
        rst = 1'b1;
        #1;
        check("t1_we_drop", 32'(mem_we), 32'd0);
        check("t1_cs_drop", 32'(mem_cs), 32'd0);
        check("t1_retire", 32'(retire), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_pc", 32'(pc), 32'h00);
        check("t1_ac", 32'(ac), 32'h00);
        @(negedge clk);
        @(negedge clk);
        check("t1_mem06_unchanged", 32'(mem[8'h06]), 32'h00);
        check("t1_no_pending", 32'(exp_q.size()), 32'd0);

        // 2: Fibonacci program
        fib_code = '{8'h10, 8'h1C, 8'h30, 8'h1D, 8'h30, 8'h1E, 8'h20, 8'h1F, 8'h10, 8'h1D,
                     8'h20, 8'h1E, 8'h10, 8'h1F, 8'h20, 8'h1D, 8'h10, 8'h20, 8'h40, 8'h21,
                     8'h20, 8'h20, 8'h81, 8'h00, 8'h90, 8'h00, 8'h70, 8'h00};
        fib_data = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h0B, 8'h01};
        clear_prog();
        for (int i = 0; i < 28; i++) prog[i] = fib_code[i];
        for (int i = 0; i < 6; i++) prog[8'h1C + i] = fib_data[i];
        do_reset();
        x = 8'h01; y = 8'h00; c = 8'h0B;
        for (int it = 0; it < 11; it++) begin
            s = 8'(x + y);
            push(5, 8'h02, 8'h00);
            push(5, 8'h04, x);
            push(5, 8'h06, s);
            push(4, 8'h08, s);
            push(5, 8'h0A, x);
            push(4, 8'h0C, x);
            push(5, 8'h0E, s);
            push(4, 8'h10, s);
            push(5, 8'h12, c);
            push(5, 8'h14, 8'(c - 8'd1));
            push(4, 8'h16, 8'(c - 8'd1));
            if (c == 8'd1) begin
                push(4, 8'h1A, 8'h00);
                push(3, 8'h1C, 8'h00);
            end else begin
                push(4, 8'h18, 8'(c - 8'd1));
                push(4, 8'h00, 8'(c - 8'd1));
            end
            y = x;
            x = s;
            c = 8'(c - 8'd1);
        end
        run_to_halt("t2");
        check("t2_halted", 32'(halted), 32'd1);
        check("t2_mem1F", 32'(mem[8'h1F]), 32'h90);
        check("t2_mem20", 32'(mem[8'h20]), 32'h00);
        check("t2_pc", 32'(pc), 32'h1C);
        check("t2_busy", 32'(busy), 32'd0);

        // 3: signed overflow into negative, SKIP >0 not taken, SKIP <0 taken
        clear_prog();
        prog[8'h00] = 8'h10; prog[8'h01] = 8'h1D;
        prog[8'h02] = 8'h30; prog[8'h03] = 8'h1E;
        prog[8'h04] = 8'h82;
        prog[8'h06] = 8'h80;
        prog[8'h0A] = 8'h70;
        prog[8'h1D] = 8'h7F; prog[8'h1E] = 8'h01;
        do_reset();
        push(5, 8'h02, 8'h7F);
        push(5, 8'h04, 8'h80);
        push(4, 8'h06, 8'h80);
        push(4, 8'h0A, 8'h80);
        push(3, 8'h0C, 8'h80);
        run_to_halt("t3");
        check("t3_ac", 32'(ac), 32'h80);

        // 5: pc wrap on taken SKIP at FE; JUMP to FF fetches IR2 from 00
        clear_prog();
        prog[8'h00] = 8'h90; prog[8'h01] = 8'hFE;
        prog[8'h02] = 8'h90; prog[8'h03] = 8'hFC;
        prog[8'hFC] = 8'h90; prog[8'hFD] = 8'hFF;
        prog[8'hFE] = 8'h81; prog[8'hFF] = 8'h90;
        prog[8'h90] = 8'h70;
        do_reset();
        push(4, 8'hFE, 8'h00);
        push(4, 8'h02, 8'h00);
        push(4, 8'hFC, 8'h00);
        push(4, 8'hFF, 8'h00);
        push(4, 8'h90, 8'h00);
        push(3, 8'h92, 8'h00);
        run_to_halt("t5");
        check("t5_pc", 32'(pc), 32'h92);

        // 6: undefined opcode NOP, CLEAR, start ignored in HALT
        clear_prog();
        prog[8'h00] = 8'h10; prog[8'h01] = 8'h08;
        prog[8'h02] = 8'h50;
        prog[8'h04] = 8'hA0;
        prog[8'h06] = 8'h70;
        prog[8'h08] = 8'h3C;
        do_reset();
        push(5, 8'h02, 8'h3C);
        push(4, 8'h04, 8'h3C);
        push(4, 8'h06, 8'h00);
        push(3, 8'h08, 8'h00);
        run_to_halt("t6");
        pulse_start();
        repeat (10) @(negedge clk);
        check("t6_still_halted", 32'(halted), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_pc", 32'(pc), 32'h08);
        check("t6_ac", 32'(ac), 32'h00);
        check("t6_cs_idle", 32'(mem_cs), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
